// File: rtl/rv_int_pkg.sv
// Shared definitions for the interrupt controller and the core's trap logic.
package rv_int_pkg;

    // Interrupt handshake state
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } int_state_e;

    // Config register select values
    localparam logic CFG_SEL_EN   = 1'b0;
    localparam logic CFG_SEL_MODE = 1'b1;

    // Trap vector the core jumps to when it takes INT
    localparam logic [31:0] INT_VEC = 32'h0000000c;

endpackage

// File: rtl/rv_int_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module rv_int_prio_enc #(
    parameter int unsigned NSRC = 8,
    parameter int unsigned ID_W = 3
) (
    input  logic [NSRC-1:0] vec_i,
    output logic            valid_o,
    output logic [ID_W-1:0] id_o
);

    // Scan upward and keep the first hit
    always_comb begin
        valid_o = 1'b0;
        id_o    = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (vec_i[i] && !valid_o) begin
                valid_o = 1'b1;
                id_o    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/rv_int_ctrl.sv
// Interrupt source controller: synchronise, latch, mask, prioritise and
// hand one request at a time to the core via the INT / ack / mret handshake.
module rv_int_ctrl
    import rv_int_pkg::*;
#(
    parameter int unsigned NSRC = 8,
    parameter int unsigned ID_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src,
    input  logic            cfg_we,
    input  logic            cfg_sel,
    input  logic [NSRC-1:0] cfg_wdata,
    output logic [NSRC-1:0] cfg_rdata,
    input  logic            int_ack,
    input  logic            int_done,
    output logic            INT,
    output logic [ID_W-1:0] int_id,
    output logic [NSRC-1:0] pending,
    output logic            in_service
);

    logic [NSRC-1:0] s1_q, s2_q, s3_q;
    logic [NSRC-1:0] edge_q;
    logic [NSRC-1:0] enable_q, mode_q;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] eligible;
    logic            win_valid;
    logic [ID_W-1:0] win_id;

    int_state_e      state_q, state_d;
    logic            int_req_q, int_req_d;
    logic [ID_W-1:0] int_id_q, int_id_d;
    logic            in_service_q, in_service_d;

    // Synchroniser chain plus registered rising-edge pulse; the pulse
    // register puts edge sources one cycle behind level sources.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            edge_q <= '0;
        end else begin
            s1_q   <= irq_src;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            edge_q <= s2_q & ~s3_q;
        end
    end

    // Enable / mode configuration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q <= '0;
            mode_q   <= '0;
        end else if (cfg_we) begin
            if (cfg_sel == CFG_SEL_MODE) begin
                mode_q <= cfg_wdata;
            end else begin
                enable_q <= cfg_wdata;
            end
        end
    end

    assign cfg_rdata = (cfg_sel == CFG_SEL_MODE) ? mode_q : enable_q;

    // Pending next state: edge bits latch (set beats claim-clear), level bits follow s2
    always_comb begin
        clr = '0;
        if (state_q == ST_REQ && int_ack) begin
            clr = NSRC'(1) << int_id_q;
        end
        pending_d = (mode_q & ((pending_q & ~clr) | edge_q)) | (~mode_q & s2_q);
    end

    // Pending register
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign eligible = pending_q & enable_q;

    rv_int_prio_enc #(
        .NSRC (NSRC),
        .ID_W (ID_W)
    ) u_prio (
        .vec_i   (eligible),
        .valid_o (win_valid),
        .id_o    (win_id)
    );

    // Handshake state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            int_req_q    <= 1'b0;
            int_id_q     <= '0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            int_req_q    <= int_req_d;
            int_id_q     <= int_id_d;
            in_service_q <= in_service_d;
        end
    end

    // Next-state logic; ack wins over a simultaneous done or eligibility drop
    always_comb begin
        state_d      = state_q;
        int_req_d    = int_req_q;
        int_id_d     = int_id_q;
        in_service_d = in_service_q;
        unique case (state_q)
            ST_IDLE: begin
                int_req_d = win_valid;
                int_id_d  = win_id;
                if (win_valid) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    int_req_d    = 1'b0;
                    in_service_d = 1'b1;
                    state_d      = ST_SERVICE;
                end else if (!win_valid) begin
                    int_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    int_req_d = 1'b1;
                    int_id_d  = win_id;
                end
            end
            ST_SERVICE: begin
                int_req_d = 1'b0;
                if (int_done) begin
                    in_service_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                int_req_d    = 1'b0;
                in_service_d = 1'b0;
            end
        endcase
    end

    assign INT        = int_req_q;
    assign int_id     = int_id_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;

endmodule
